// File: rtl/spmv_csr_fetch_pkg.sv
// spmv_pkg: shared constants and the fetcher state encoding for the
// SpMV CSR operand fetcher (spmv_csr_fetch) and its row_ptr loader.
//   N_ROWS      matrix rows
//   DW          fp16 data width (value and vector element)
//   IW          nonzero index / row_ptr entry width
//   CW          column index width
//   RP_ENTRIES  row_ptr entries (N_ROWS+1)
//   RP_AW       row_ptr address / sequencing counter width
package spmv_pkg;

  localparam int N_ROWS     = 16;
  localparam int DW         = 16;
  localparam int IW         = 8;
  localparam int CW         = 4;
  localparam int RP_ENTRIES = N_ROWS + 1;
  localparam int RP_AW      = $clog2(RP_ENTRIES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RP_RD    = 3'd1,
    NZ_RD    = 3'd2,
    NZ_WAIT  = 3'd3,
    VEC_WAIT = 3'd4,
    PRESENT  = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/spmv_csr_fetch_if.sv
// spmv_csr_fetch_if: operand-pair stream from the fetcher to the SpMV core.
//   valid   pair valid (source)
//   ready   core accepts the pair (sink)
//   data_a  nonzero value val[k]
//   data_b  vector element x[col[k]]
//   count   nonzero index k
// Modports: master = fetcher side, slave = core side.
interface spmv_csr_fetch_if;
  import spmv_pkg::*;

  logic          valid;
  logic          ready;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [IW-1:0] count;

  modport master (output valid, output data_a, output data_b, output count, input ready);
  modport slave  (input valid, input data_a, input data_b, input count, output ready);

endinterface

// File: rtl/spmv_csr_fetch_rowptr_loader.sv
// spmv_rowptr_loader: reads the RP_ENTRIES row_ptr words from a memory with
// one cycle of read latency and packs them into one register.
//   i_clk, i_rstn  clock, asynchronous active-low reset
//   start          begin a load (one-cycle pulse)
//   rp_en/rp_addr  row_ptr memory read port
//   rp_data        row_ptr read data (one cycle after rp_en)
//   row_ptr        packed row_ptr, entry i at [i*IW +: IW]; held between loads
//   done           one-cycle pulse in the final sequencing cycle, the same
//                  cycle the last entry is on rp_data
module spmv_rowptr_loader
  import spmv_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       start,
  output logic                       rp_en,
  output logic [RP_AW-1:0]           rp_addr,
  input  logic [IW-1:0]              rp_data,
  output logic [IW*RP_ENTRIES-1:0]   row_ptr,
  output logic                       done
);

  localparam logic [RP_AW-1:0] J_LAST = RP_AW'(RP_ENTRIES);

  logic             active;
  logic [RP_AW-1:0] j;

  // j runs 0..RP_ENTRIES: reads issue for j < RP_ENTRIES, the word read at
  // j-1 is captured at j, so the sequence is one cycle longer than the reads.
  assign rp_en   = active && (j < J_LAST);
  assign rp_addr = rp_en ? j : '0;
  assign done    = active && (j == J_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      active  <= 1'b0;
      j       <= '0;
      row_ptr <= '0;
    end else begin
      if (start) begin
        active <= 1'b1;
        j      <= '0;
      end else if (active) begin
        if (j == J_LAST) active <= 1'b0;
        j <= j + 1'b1;
      end
      if (active && (j != '0))
        row_ptr[(int'(j) - 1) * IW +: IW] <= rp_data;
    end
  end

endmodule

// File: rtl/spmv_csr_fetch.sv
// spmv_csr_fetch: upstream feeder for the SpMV compute core.
// On i_start it loads row_ptr, then for each nonzero k reads val[k]/col[k],
// reads x[col[k]] and presents {val, x, k} on the op stream; o_done pulses
// after the last pair is accepted (or right after the load for nnz = 0).
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_start                start pulse, ignored while busy
//   o_busy, o_done         status
//   o_rp_*/i_rp_data       row_ptr memory port (1-cycle latency)
//   o_nz_*/i_val/i_col     value/column memory port (1-cycle latency)
//   o_vec_*/i_vec_data     vector memory port (1-cycle latency)
//   op                     operand-pair stream (spmv_csr_fetch_if.master)
//   o_row_ptr              packed row_ptr
//   o_stall_cnt            present only with `define SPMV_FETCH_STALL_CNT_EN:
//                          cycles with valid && !ready, saturating
module spmv_csr_fetch
  import spmv_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [RP_AW-1:0]          o_rp_addr,
  output logic                      o_rp_en,
  input  logic [IW-1:0]             i_rp_data,
  output logic [IW-1:0]             o_nz_addr,
  output logic                      o_nz_en,
  input  logic [DW-1:0]             i_val_data,
  input  logic [CW-1:0]             i_col_data,
  output logic [CW-1:0]             o_vec_addr,
  output logic                      o_vec_en,
  input  logic [DW-1:0]             i_vec_data,
  spmv_csr_fetch_if.master          op,
  output logic [IW*RP_ENTRIES-1:0]  o_row_ptr
`ifdef SPMV_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]               o_stall_cnt
`endif
);

  state_t        state;
  logic [IW-1:0] k;
  logic [IW-1:0] nnz_last;
  logic          ld_start;
  logic          ld_done;
  logic          valid;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [IW-1:0] count;

  assign ld_start = (state == IDLE) && i_start;
  // Only meaningful once nnz > 0, which is the only case that reaches PRESENT.
  assign nnz_last = o_row_ptr[N_ROWS*IW +: IW] - 1'b1;

  spmv_rowptr_loader u_loader (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .start   (ld_start),
    .rp_en   (o_rp_en),
    .rp_addr (o_rp_addr),
    .rp_data (i_rp_data),
    .row_ptr (o_row_ptr),
    .done    (ld_done)
  );

  // The vector address is the column word arriving this cycle, so this read
  // port cannot be registered without adding a cycle per element.
  assign o_vec_en   = (state == NZ_WAIT);
  assign o_vec_addr = o_vec_en ? i_col_data : '0;

  assign op.valid  = valid;
  assign op.data_a = data_a;
  assign op.data_b = data_b;
  assign op.count  = count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      k         <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_nz_en   <= 1'b0;
      o_nz_addr <= '0;
      valid     <= 1'b0;
      data_a    <= '0;
      data_b    <= '0;
      count     <= '0;
    end else begin
      o_done  <= 1'b0;
      o_nz_en <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= RP_RD;
            k      <= '0;
            o_busy <= 1'b1;
          end
        end
        RP_RD: begin
          // Entry 16 (nnz) is on i_rp_data in the loader's last cycle.
          if (ld_done) begin
            if (i_rp_data == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state     <= NZ_RD;
              o_nz_en   <= 1'b1;
              o_nz_addr <= k;
            end
          end
        end
        NZ_RD: state <= NZ_WAIT;
        NZ_WAIT: begin
          data_a <= i_val_data;
          state  <= VEC_WAIT;
        end
        VEC_WAIT: begin
          data_b <= i_vec_data;
          count  <= k;
          valid  <= 1'b1;
          state  <= PRESENT;
        end
        PRESENT: begin
          if (op.ready) begin
            valid <= 1'b0;
            if (k == nnz_last) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              k         <= k + 1'b1;
              o_nz_en   <= 1'b1;
              o_nz_addr <= k + 1'b1;
              state     <= NZ_RD;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPMV_FETCH_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
    end else if (ld_start) begin
      o_stall_cnt <= '0;
    end else if (valid && !op.ready && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Directed bench for spmv_csr_fetch: table of matrix scenarios applied in a
// loop against behavioural memories, plus hand-written reset-in-PRESENT and
// reload sequences.
module tb_spmv_csr_fetch;
  import spmv_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic                     busy, done, rp_en, nz_en, vec_en;
  logic [RP_AW-1:0]         rp_addr;
  logic [IW-1:0]            rp_data = '0;
  logic [IW-1:0]            nz_addr;
  logic [DW-1:0]            val_data = '0;
  logic [DW-1:0]            vec_data = '0;
  logic [CW-1:0]            col_data = '0;
  logic [CW-1:0]            vec_addr;
  logic [IW*RP_ENTRIES-1:0] row_ptr;
`ifdef SPMV_FETCH_STALL_CNT_EN
  logic [15:0]              stall_cnt;
`endif

  spmv_csr_fetch_if op_if ();

  spmv_csr_fetch dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_rp_addr  (rp_addr),
    .o_rp_en    (rp_en),
    .i_rp_data  (rp_data),
    .o_nz_addr  (nz_addr),
    .o_nz_en    (nz_en),
    .i_val_data (val_data),
    .i_col_data (col_data),
    .o_vec_addr (vec_addr),
    .o_vec_en   (vec_en),
    .i_vec_data (vec_data),
    .op         (op_if),
    .o_row_ptr  (row_ptr)
`ifdef SPMV_FETCH_STALL_CNT_EN
    ,
    .o_stall_cnt(stall_cnt)
`endif
  );

  // Behavioural memories with one cycle of read latency.
  logic [IW-1:0] rp_mem  [RP_ENTRIES];
  logic [DW-1:0] val_mem [256];
  logic [CW-1:0] col_mem [256];
  logic [DW-1:0] vec_mem [N_ROWS];

  always @(posedge clk) begin
    if (rp_en) rp_data <= rp_mem[rp_addr];
    if (nz_en) begin
      val_data <= val_mem[nz_addr];
      col_data <= col_mem[nz_addr];
    end
    if (vec_en) vec_data <= vec_mem[vec_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [IW*RP_ENTRIES-1:0] act,
                       input logic [IW*RP_ENTRIES-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // 0 diagonal, 1 empty, 2 single nonzero, 3 five nonzeros over three rows
  task automatic load_matrix(input int mode);
    logic [IW-1:0] pat_rp  [RP_ENTRIES];
    logic [CW-1:0] pat_col [5];
    pat_rp  = '{8'd0, 8'd2, 8'd2, 8'd3, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5,
                8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    pat_col = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd9};
    for (int i = 0; i < 256; i++) begin
      val_mem[i] = '0;
      col_mem[i] = '0;
    end
    for (int i = 0; i < N_ROWS; i++) vec_mem[i] = '0;
    for (int i = 0; i < RP_ENTRIES; i++) begin
      case (mode)
        0:       rp_mem[i] = IW'(i);
        1:       rp_mem[i] = '0;
        2:       rp_mem[i] = (i == 0) ? 8'd0 : 8'd1;
        default: rp_mem[i] = pat_rp[i];
      endcase
    end
    case (mode)
      0: for (int i = 0; i < N_ROWS; i++) begin
           val_mem[i] = 16'h3C00;
           col_mem[i] = CW'(i);
           vec_mem[i] = DW'(i);
         end
      2: begin
           val_mem[0] = 16'h3C00;
           col_mem[0] = 4'd7;
           vec_mem[7] = 16'h4000;
         end
      3: begin
           for (int i = 0; i < 5; i++) begin
             val_mem[i] = 16'h1100 + DW'(i);
             col_mem[i] = pat_col[i];
           end
           for (int i = 0; i < N_ROWS; i++) vec_mem[i] = 16'h2000 + DW'(i);
         end
      default: ;
    endcase
  endtask

  function automatic logic [IW*RP_ENTRIES-1:0] packed_rp();
    logic [IW*RP_ENTRIES-1:0] r;
    r = '0;
    for (int i = 0; i < RP_ENTRIES; i++) r[i*IW +: IW] = rp_mem[i];
    return r;
  endfunction

  typedef struct {
    int            mode;
    int            stall_k;     // -1: no backpressure
    int            stall_len;
    int            mid_start;   // cycle of a stray i_start, 0: none
    int            exp_nnz;
    logic [DW-1:0] exp_last_b;
  } case_t;

  case_t cases [5];

  task automatic run_case(input int idx, input case_t c);
    int            cyc, txn, stalled, done_cyc, exp_stall;
    logic          got_done;
    logic [DW-1:0] held_a, held_b, last_b;
    logic [IW-1:0] held_cnt;
    string         tag;
    tag = $sformatf("case%0d", idx);
    load_matrix(c.mode);
    exp_stall = (c.stall_k >= 0 && c.stall_k < c.exp_nnz) ? c.stall_len : 0;
    cyc = 0; txn = 0; stalled = 0; done_cyc = -1; got_done = 1'b0;
    held_a = '0; held_b = '0; held_cnt = '0; last_b = '0;
    @(negedge clk);
    start = 1'b1;
    op_if.ready = 1'b1;
    while (cyc < 400 && !got_done) begin
      @(negedge clk);
      cyc++;
      start = (c.mid_start != 0) && (cyc == c.mid_start);
      if (cyc == 1) check({tag, "_busy"}, busy, 1'b1);
      if (op_if.valid) begin
        if (int'(op_if.count) == c.stall_k && stalled < c.stall_len) begin
          if (stalled == 0) begin
            held_a = op_if.data_a; held_b = op_if.data_b; held_cnt = op_if.count;
          end else begin
            check({tag, "_hold_a"}, op_if.data_a, held_a);
            check({tag, "_hold_b"}, op_if.data_b, held_b);
            check({tag, "_hold_cnt"}, op_if.count, held_cnt);
          end
          op_if.ready = 1'b0;
          stalled++;
        end else begin
          op_if.ready = 1'b1;
          check({tag, "_count"}, op_if.count, IW'(txn));
          check({tag, "_data_a"}, op_if.data_a, val_mem[txn]);
          check({tag, "_data_b"}, op_if.data_b, vec_mem[col_mem[txn]]);
          last_b = op_if.data_b;
          txn++;
        end
      end else begin
        op_if.ready = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_done_cycle"}, done_cyc, 19 + 4 * c.exp_nnz + exp_stall);
    check({tag, "_txn_count"}, txn, c.exp_nnz);
    if (c.exp_nnz > 0) check({tag, "_last_b"}, last_b, c.exp_last_b);
    check({tag, "_row_ptr"}, row_ptr, packed_rp());
    check({tag, "_nnz_entry"}, row_ptr[N_ROWS*IW +: IW], IW'(c.exp_nnz));
`ifdef SPMV_FETCH_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int   n;
    logic seen_done;
    cases[0] = '{mode: 0, stall_k: -1, stall_len: 0, mid_start: 0,  exp_nnz: 16, exp_last_b: 16'h000F};
    cases[1] = '{mode: 1, stall_k: -1, stall_len: 0, mid_start: 0,  exp_nnz: 0,  exp_last_b: 16'h0000};
    cases[2] = '{mode: 0, stall_k: 2,  stall_len: 5, mid_start: 0,  exp_nnz: 16, exp_last_b: 16'h000F};
    cases[3] = '{mode: 2, stall_k: -1, stall_len: 0, mid_start: 0,  exp_nnz: 1,  exp_last_b: 16'h4000};
    cases[4] = '{mode: 3, stall_k: 1,  stall_len: 2, mid_start: 30, exp_nnz: 5,  exp_last_b: 16'h2009};
    load_matrix(1);
    op_if.ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", op_if.valid, 1'b0);
    check("rst_count", op_if.count, '0);
    check("rst_data_a", op_if.data_a, '0);
    check("rst_data_b", op_if.data_b, '0);
    check("rst_row_ptr", row_ptr, '0);
    check("rst_enables", {rp_en, nz_en, vec_en}, 3'b000);
`ifdef SPMV_FETCH_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, '0);
`endif
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_case(i, cases[i]);

    // Reset while a pair is being presented under backpressure
    load_matrix(0);
    @(negedge clk);
    start = 1'b1;
    op_if.ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!op_if.valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_present", op_if.valid, 1'b1);
    check("mid_data_a", op_if.data_a, 16'h3C00);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", op_if.valid, 1'b0);
    check("mid_rst_data_a", op_if.data_a, '0);
    check("mid_rst_count", op_if.count, '0);
    check("mid_rst_row_ptr", row_ptr, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_enables", {rp_en, nz_en, vec_en}, 3'b000);
    @(negedge clk);
    rstn = 1'b1;
    op_if.ready = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("mid_rst_no_done", seen_done, 1'b0);

    // Fresh start after the abort reloads row_ptr and runs normally
    run_case(5, cases[3]);
    run_case(6, cases[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
